// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory and the controller driving op.
//   - op encodings (dm_op_e), address geometry, store-trace payload struct.
package dm_pkg;

    localparam int unsigned DM_ADDR_MSB = 11;
    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int unsigned IDX_W       = DM_ADDR_MSB - 1;

    typedef enum logic [2:0] {
        DM_W  = 3'd0,
        DM_H  = 3'd1,
        DM_HU = 3'd2,
        DM_B  = 3'd3,
        DM_BU = 3'd4
    } dm_op_e;

    // One committed store, as reported on the trace port.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } dm_trace_t;

endpackage

// File: rtl/dm_mem_stage_if.sv
// MEM-stage data memory bus.
//   master (pipeline): drives pc, addr, wd, we, op; receives rd, addr_err, trace.
//   slave  (memory)  : receives access, returns combinational rd/addr_err and
//                      a registered record of the store committed last edge.
interface dm_mem_stage_if;
    import dm_pkg::*;

    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  op;
    logic [31:0] rd;
    logic        addr_err;
    logic        trace_vld;
    dm_trace_t   trace;

    modport master (
        output pc, addr, wd, we, op,
        input  rd, addr_err, trace_vld, trace
    );

    modport slave (
        input  pc, addr, wd, we, op,
        output rd, addr_err, trace_vld, trace
    );

endinterface

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension.
//   word : full 32-bit word read from the array
//   lane : byte offset addr[1:0]
//   op   : access type (dm_op_e encoding)
//   rd   : extended load data (0 for unknown op)
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  op,
    output logic [31:0] rd
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select: byte by full lane, half by upper lane bit.
    always_comb begin
        shifted  = word >> {lane, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    // Extension by access type.
    always_comb begin
        rd = '0;
        case (op)
            DM_W:    rd = word;
            DM_H:    rd = {{16{half_sel[15]}}, half_sel};
            DM_HU:   rd = {16'h0000, half_sel};
            DM_B:    rd = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   rd = {24'h000000, byte_sel};
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/dm_mem_stage.sv
// MEM-stage data memory: 4 KiB byte-addressed, word-organised array.
//   clk, reset : clock and synchronous active-high reset (clears the array)
//   bus.slave  : pc/addr/wd/we/op in; rd/addr_err combinational out;
//                trace_vld/trace registered record of the store committed
//                at the previous edge (pc, word address, merged word).
module dm_mem_stage
    import dm_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    dm_mem_stage_if.slave   bus
);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      cur_word;
    logic [31:0]      merged;
    logic [31:0]      ext_rd;
    logic             op_ok;
    logic             out_of_range;
    logic             misaligned;
    logic             addr_err_c;
    logic             commit_c;

    assign idx      = bus.addr[DM_ADDR_MSB:2];
    assign lane     = bus.addr[1:0];
    assign cur_word = mem[idx];

    // Range and alignment checks apply to loads and stores alike.
    always_comb begin
        out_of_range = |bus.addr[31:DM_ADDR_MSB+1];
        misaligned   = 1'b0;
        case (bus.op)
            DM_W:        misaligned = (lane != 2'b00);
            DM_H, DM_HU: misaligned = lane[0];
            default:     misaligned = 1'b0;
        endcase
        addr_err_c = out_of_range | misaligned;
    end

    // Store byte-lane merge into the current word; unknown op never writes.
    always_comb begin
        merged = cur_word;
        op_ok  = 1'b1;
        case (bus.op)
            DM_W: merged = bus.wd;
            DM_H, DM_HU: begin
                if (lane[1]) merged[31:16] = bus.wd[15:0];
                else         merged[15:0]  = bus.wd[15:0];
            end
            DM_B, DM_BU: merged[{lane, 3'b000} +: 8] = bus.wd[7:0];
            default: op_ok = 1'b0;
        endcase
    end

    assign commit_c = bus.we & ~addr_err_c & op_ok;

    dm_load_ext u_load_ext (
        .word (cur_word),
        .lane (lane),
        .op   (bus.op),
        .rd   (ext_rd)
    );

    assign bus.rd       = addr_err_c ? '0 : ext_rd;
    assign bus.addr_err = addr_err_c;

    // Array update and store trace; reset overrides a simultaneous store.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem           <= '{default: '0};
            bus.trace_vld <= 1'b0;
            bus.trace     <= '0;
        end else begin
            if (commit_c) begin
                mem[idx] <= merged;
            end
            bus.trace_vld  <= commit_c;
            bus.trace.pc   <= bus.pc;
            bus.trace.addr <= {bus.addr[31:2], 2'b00};
            bus.trace.data <= merged;
        end
    end

endmodule

// File: tb/tb_dm_mem_stage.sv
// Directed bench for dm_mem_stage: inputs change on negedge, outputs sampled
// 1 time unit later; stores commit at the intervening posedge.
module tb_dm_mem_stage;
    import dm_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    dm_mem_stage_if bus ();

    dm_mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] wd, input logic we, input logic [2:0] op);
        @(negedge clk);
        reset    = rst;
        bus.pc   = pc;
        bus.addr = addr;
        bus.wd   = wd;
        bus.we   = we;
        bus.op   = op;
        #1;
    endtask

    // Store trace printout.
    always @(negedge clk) begin
        if (!reset && bus.trace_vld === 1'b1)
            $display("@%08h: *%08h <= %08h", bus.trace.pc, bus.trace.addr, bus.trace.data);
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=%08h exp=%08h", 32'h0, 32'h1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.pc = '0; bus.addr = '0; bus.wd = '0; bus.we = 1'b0; bus.op = DM_W;
        drive(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, DM_W);
        drive(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, DM_W);

        // Post-reset contents
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, DM_W);
        chk("rst_lw0_rd", bus.rd, 32'h0);
        chk("rst_lw0_err", 32'(bus.addr_err), 32'h0);
        chk("rst_trace", 32'(bus.trace_vld), 32'h0);
        drive(1'b0, 32'h0, 32'hFFC, 32'h0, 1'b0, DM_W);
        chk("rst_lwffc_rd", bus.rd, 32'h0);
        chk("rst_lwffc_err", 32'(bus.addr_err), 32'h0);

        // Word store then sub-word loads
        drive(1'b0, 32'h0040_0100, 32'h10, 32'h1234_5678, 1'b1, DM_W);
        chk("sw10_err", 32'(bus.addr_err), 32'h0);
        drive(1'b0, 32'h0, 32'h13, 32'h0, 1'b0, DM_B);
        chk("sw10_trace_vld", 32'(bus.trace_vld), 32'h1);
        chk("sw10_trace_pc", bus.trace.pc, 32'h0040_0100);
        chk("sw10_trace_addr", bus.trace.addr, 32'h10);
        chk("sw10_trace_data", bus.trace.data, 32'h1234_5678);
        chk("lb13", bus.rd, 32'h0000_0012);
        drive(1'b0, 32'h0, 32'h13, 32'h0, 1'b0, DM_BU);
        chk("lbu13", bus.rd, 32'h0000_0012);
        chk("trace_clear", 32'(bus.trace_vld), 32'h0);
        drive(1'b0, 32'h0, 32'h12, 32'h0, 1'b0, DM_H);
        chk("lh12", bus.rd, 32'h0000_1234);
        drive(1'b0, 32'h0, 32'h10, 32'h0, 1'b0, DM_HU);
        chk("lhu10", bus.rd, 32'h0000_5678);
        drive(1'b0, 32'h0, 32'h10, 32'h0, 1'b0, DM_B);
        chk("lb10", bus.rd, 32'h0000_0078);

        // Byte and half merges
        drive(1'b0, 32'h0040_0104, 32'h20, 32'h0, 1'b1, DM_W);
        drive(1'b0, 32'h0040_0108, 32'h21, 32'hFFFF_FF80, 1'b1, DM_B);
        drive(1'b0, 32'h0040_010C, 32'h22, 32'h0000_BEEF, 1'b1, DM_H);
        chk("sb21_trace_data", bus.trace.data, 32'h0000_8000);
        drive(1'b0, 32'h0, 32'h20, 32'h0, 1'b0, DM_W);
        chk("sh22_trace_addr", bus.trace.addr, 32'h20);
        chk("lw20", bus.rd, 32'hBEEF_8000);
        drive(1'b0, 32'h0, 32'h21, 32'h0, 1'b0, DM_B);
        chk("lb21", bus.rd, 32'hFFFF_FF80);
        drive(1'b0, 32'h0, 32'h21, 32'h0, 1'b0, DM_BU);
        chk("lbu21", bus.rd, 32'h0000_0080);
        drive(1'b0, 32'h0, 32'h22, 32'h0, 1'b0, DM_H);
        chk("lh22", bus.rd, 32'hFFFF_BEEF);
        drive(1'b0, 32'h0, 32'h22, 32'h0, 1'b0, DM_HU);
        chk("lhu22", bus.rd, 32'h0000_BEEF);
        drive(1'b0, 32'h0, 32'h23, 32'h0, 1'b0, DM_B);
        chk("lb23", bus.rd, 32'hFFFF_FFBE);

        // Misaligned accesses
        drive(1'b0, 32'h0040_0110, 32'h22, 32'h1111_1111, 1'b1, DM_W);
        chk("sw22_err", 32'(bus.addr_err), 32'h1);
        chk("sw22_rd", bus.rd, 32'h0);
        drive(1'b0, 32'h0, 32'h20, 32'h0, 1'b0, DM_W);
        chk("sw22_no_trace", 32'(bus.trace_vld), 32'h0);
        chk("sw22_no_write", bus.rd, 32'hBEEF_8000);
        drive(1'b0, 32'h0, 32'h31, 32'h0, 1'b0, DM_H);
        chk("lh31_err", 32'(bus.addr_err), 32'h1);
        chk("lh31_rd", bus.rd, 32'h0);
        drive(1'b0, 32'h0, 32'h23, 32'h0, 1'b0, DM_HU);
        chk("lhu23_err", 32'(bus.addr_err), 32'h1);

        // Out of range
        drive(1'b0, 32'h0040_0114, 32'h1000, 32'hDEAD_BEEF, 1'b1, DM_W);
        chk("sw1000_err", 32'(bus.addr_err), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, DM_W);
        chk("sw1000_no_trace", 32'(bus.trace_vld), 32'h0);
        chk("lw0_after_oor", bus.rd, 32'h0);
        chk("lw0_after_oor_err", 32'(bus.addr_err), 32'h0);

        // Reset wins over a simultaneous store and clears the array
        drive(1'b1, 32'h0040_0118, 32'h40, 32'hAAAA_5555, 1'b1, DM_W);
        drive(1'b0, 32'h0, 32'h40, 32'h0, 1'b0, DM_W);
        chk("rst_sw40_rd", bus.rd, 32'h0);
        chk("rst_sw40_trace", 32'(bus.trace_vld), 32'h0);
        drive(1'b0, 32'h0, 32'h20, 32'h0, 1'b0, DM_W);
        chk("rst_cleared_20", bus.rd, 32'h0);

        // Same-cycle store and load return pre-store contents
        drive(1'b0, 32'h0040_011C, 32'h40, 32'h0102_0304, 1'b1, DM_W);
        drive(1'b0, 32'h0040_0120, 32'h40, 32'hAAAA_5555, 1'b1, DM_W);
        chk("sw40_same_cycle_rd", bus.rd, 32'h0102_0304);
        drive(1'b0, 32'h0, 32'h40, 32'h0, 1'b0, DM_W);
        chk("sw40_next_cycle_rd", bus.rd, 32'hAAAA_5555);
        chk("sw40_trace_data", bus.trace.data, 32'hAAAA_5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
